// File: rtl/pic_ack_sequencer.sv
// Interrupt acknowledge sequencer for the 8259-style block: raises INT under fully-nested
// masking, runs the two-pulse INTA handshake, drives the vector and owns the in-service register.
module pic_ack_sequencer #(
   parameter logic [4:0] RESET_BASE = 5'b00001
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       int_req,
   input  logic [7:0] chosen_interrupt,
   input  logic       inta_n,
   input  logic [4:0] vector_base,
   input  logic       aeoi,
   input  logic       eoi_valid,
   input  logic       eoi_specific,
   input  logic [2:0] eoi_level,
   output logic       int_out,
   output logic [7:0] isr,
   output logic [7:0] clear_irr,
   output logic [7:0] data_out,
   output logic       data_oe,
   output logic       busy
);

   localparam int unsigned NUM_IRQ = 8;
   localparam int unsigned LVL_W   = 3;

   typedef enum logic [1:0] {IDLE, ACK1, GAP, ACK2} state_t;

   // The base normally comes from vector_base; the parameter only documents the power-up assumption.
   if (RESET_BASE == 5'd0) begin : g_zero_base_hint
   end

   state_t             state;
   logic               inta_prev;
   logic [LVL_W-1:0]   level;
   logic               spurious;

   logic               fall;
   logic               rise;
   logic [LVL_W-1:0]   sel;
   logic [LVL_W-1:0]   top;
   logic               sel_valid;
   logic               eligible;
   logic               ack_start;
   logic [NUM_IRQ-1:0] isr_set;
   logic [NUM_IRQ-1:0] isr_clr;

   function automatic logic [LVL_W-1:0] lowest_idx(input logic [NUM_IRQ-1:0] v);
      lowest_idx = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (v[i]) lowest_idx = LVL_W'(i);
      end
   endfunction

   // Edge detect, priority compare and in-service set/clear masks
   always_comb begin
      fall      = inta_prev & ~inta_n;
      rise      = ~inta_prev & inta_n;
      sel       = lowest_idx(chosen_interrupt);
      sel_valid = |chosen_interrupt;
      top       = lowest_idx(isr);
      eligible  = int_req & sel_valid & ((isr == 8'd0) | (sel < top));
      ack_start = (state == IDLE) & fall & int_out;
      isr_set   = '0;
      isr_clr   = '0;
      if (ack_start && sel_valid) isr_set[sel] = 1'b1;
      if ((state == ACK2) && rise && aeoi && !spurious) isr_clr[level] = 1'b1;
      if (eoi_valid) begin
         if (eoi_specific)       isr_clr[eoi_level] = 1'b1;
         else if (isr != 8'd0)   isr_clr[top]       = 1'b1;
      end
   end

   // Handshake FSM with registered outputs; a set beats a simultaneous clear of the same bit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         inta_prev <= 1'b1;
         level     <= '0;
         spurious  <= 1'b0;
         isr       <= '0;
         clear_irr <= '0;
         int_out   <= 1'b0;
         data_oe   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         inta_prev <= inta_n;
         isr       <= (isr & ~isr_clr) | isr_set;
         clear_irr <= isr_set;
         int_out   <= (state == IDLE) & ~ack_start & eligible;
         case (state)
            IDLE: if (ack_start) begin
               state    <= ACK1;
               level    <= sel_valid ? sel : 3'd7;
               spurious <= ~sel_valid;
               busy     <= 1'b1;
            end
            ACK1: if (rise) state <= GAP;
            GAP: if (fall) begin
               state   <= ACK2;
               data_oe <= 1'b1;
            end
            ACK2: if (rise) begin
               state   <= IDLE;
               data_oe <= 1'b0;
               busy    <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Vector base is taken live while the bus is driven
   assign data_out = data_oe ? {vector_base, level} : 8'd0;

endmodule

// File: tb/tb_pic_ack_sequencer.sv
// Self-checking bench for pic_ack_sequencer: directed scenarios plus randomized traffic
// compared against a transaction-level reference model.
module tb_pic_ack_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       int_req;
   logic [7:0] chosen_interrupt;
   logic       inta_n;
   logic [4:0] vector_base;
   logic       aeoi;
   logic       eoi_valid;
   logic       eoi_specific;
   logic [2:0] eoi_level;
   logic       int_out;
   logic [7:0] isr;
   logic [7:0] clear_irr;
   logic [7:0] data_out;
   logic       data_oe;
   logic       busy;

   int checks   = 0;
   int failures = 0;

   // reference model: edges counts INTA edges seen inside an acknowledge (0 = no acknowledge)
   logic       m_prev;
   logic       m_int;
   logic [7:0] m_isr;
   logic [7:0] m_clr;
   int         m_lvl;
   logic       m_spur;
   int         m_edges;

   // observations captured during the last acknowledge
   logic [7:0] vec_seen;
   logic [7:0] isr_seen;
   int         clr_cnt;

   always #5 clk = ~clk;

   pic_ack_sequencer #(.RESET_BASE(5'b00001)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .int_req          (int_req),
      .chosen_interrupt (chosen_interrupt),
      .inta_n           (inta_n),
      .vector_base      (vector_base),
      .aeoi             (aeoi),
      .eoi_valid        (eoi_valid),
      .eoi_specific     (eoi_specific),
      .eoi_level        (eoi_level),
      .int_out          (int_out),
      .isr              (isr),
      .clear_irr        (clear_irr),
      .data_out         (data_out),
      .data_oe          (data_oe),
      .busy             (busy)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic int first_set(input logic [7:0] v);
      for (int i = 0; i < 8; i++) if (v[i]) return i;
      return -1;
   endfunction

   task automatic check_all();
      logic [7:0] exp_data;
      exp_data = (m_edges == 3) ? {vector_base, 3'(m_lvl)} : 8'd0;
      check_eq("int_out",   32'(int_out),   32'(m_int));
      check_eq("isr",       32'(isr),       32'(m_isr));
      check_eq("clear_irr", 32'(clear_irr), 32'(m_clr));
      check_eq("data_oe",   32'(data_oe),   32'(m_edges == 3));
      check_eq("data_out",  32'(data_out),  32'(exp_data));
      check_eq("busy",      32'(busy),      32'(m_edges != 0));
   endtask

   task automatic model_reset();
      m_prev = 1'b1; m_int = 1'b0; m_isr = '0; m_clr = '0;
      m_lvl = 0; m_spur = 1'b0; m_edges = 0;
   endtask

   // One clock: predict from current inputs, take the edge, compare just after it
   task automatic step();
      logic       fall, rise, elig;
      int         s, t, n_edges;
      logic [7:0] set_m, clr_m;
      logic       n_int;
      fall = m_prev & ~inta_n;
      rise = ~m_prev & inta_n;
      s = first_set(chosen_interrupt);
      t = first_set(m_isr);
      elig = int_req && (s >= 0) && (m_isr == 0 || s < t);
      set_m = '0; clr_m = '0; n_int = 1'b0; n_edges = m_edges;
      if (m_edges == 0) begin
         if (fall && m_int) begin
            n_edges = 1;
            m_spur  = (s < 0);
            m_lvl   = (s < 0) ? 7 : s;
            if (s >= 0) set_m = 8'(1 << s);
         end else begin
            n_int = elig;
         end
      end else if ((m_edges == 1 || m_edges == 3) && rise) begin
         n_edges = (m_edges == 3) ? 0 : 2;
         if (m_edges == 3 && aeoi && !m_spur) clr_m |= 8'(1 << m_lvl);
      end else if (m_edges == 2 && fall) begin
         n_edges = 3;
      end
      if (eoi_valid) begin
         if (eoi_specific)   clr_m |= 8'(1 << eoi_level);
         else if (m_isr != 0) clr_m |= 8'(1 << t);
      end
      m_isr   = (m_isr & ~clr_m) | set_m;
      m_clr   = set_m;
      m_int   = n_int;
      m_edges = n_edges;
      m_prev  = inta_n;
      @(posedge clk);
      #1;
      check_all();
      if (clear_irr != 0) clr_cnt++;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      @(posedge clk);
      #1;
      check_all();
      rst_n = 1'b1;
   endtask

   // Two INTA pulses: 2 low, 2 high, 2 low, then high
   task automatic inta_pulses();
      clr_cnt = 0;
      inta_n = 1'b0; step(); isr_seen = isr; step();
      inta_n = 1'b1; step(); step();
      inta_n = 1'b0; step(); vec_seen = data_out; step();
      inta_n = 1'b1; step();
   endtask

   initial begin
      rst_n = 1'b1; int_req = 1'b0; chosen_interrupt = '0; inta_n = 1'b1;
      vector_base = 5'b01000; aeoi = 1'b0; eoi_valid = 1'b0; eoi_specific = 1'b0; eoi_level = '0;
      model_reset();
      #2;
      apply_reset();

      // basic acknowledge
      int_req = 1'b1; chosen_interrupt = 8'h08;
      step();
      check_eq("basic_int", 32'(int_out), 32'd1);
      inta_pulses();
      check_eq("basic_isr", 32'(isr_seen), 32'h08);
      check_eq("basic_clr_cnt", 32'(clr_cnt), 32'd1);
      check_eq("basic_vec", 32'(vec_seen), 32'h43);
      check_eq("basic_busy", 32'(busy), 32'd0);

      // nesting: lower priority masked, higher priority nests
      chosen_interrupt = 8'h20;
      step(); step(); step();
      check_eq("nest_masked", 32'(int_out), 32'd0);
      chosen_interrupt = 8'h02;
      step();
      check_eq("nest_int", 32'(int_out), 32'd1);
      inta_pulses();
      check_eq("nest_isr", 32'(isr), 32'h0A);
      check_eq("nest_vec_lvl", 32'(vec_seen[2:0]), 32'd1);

      // EOI ordering and collision
      int_req = 1'b0;
      eoi_valid = 1'b1; eoi_specific = 1'b0;
      step();
      check_eq("eoi_ns", 32'(isr), 32'h08);
      eoi_specific = 1'b1; eoi_level = 3'd3;
      step();
      check_eq("eoi_sp", 32'(isr), 32'h00);
      eoi_valid = 1'b0;
      int_req = 1'b1; chosen_interrupt = 8'h08;
      step();
      inta_n = 1'b0; eoi_valid = 1'b1; eoi_specific = 1'b1; eoi_level = 3'd3;
      step();
      check_eq("eoi_collide", 32'(isr[3]), 32'd1);
      eoi_valid = 1'b0;
      step();
      inta_n = 1'b1; step(); step();
      inta_n = 1'b0; step(); step();
      inta_n = 1'b1; step();

      // spurious: request vanishes before the first fall
      chosen_interrupt = 8'h02;
      step();
      chosen_interrupt = 8'h00;
      inta_pulses();
      check_eq("spur_isr", 32'(isr), 32'h08);
      check_eq("spur_clr_cnt", 32'(clr_cnt), 32'd0);
      check_eq("spur_vec", 32'(vec_seen), 32'h47);

      // AEOI
      apply_reset();
      aeoi = 1'b1; int_req = 1'b1; chosen_interrupt = 8'h08;
      step();
      inta_pulses();
      check_eq("aeoi_isr_mid", 32'(isr_seen), 32'h08);
      check_eq("aeoi_isr_end", 32'(isr), 32'h00);
      aeoi = 1'b0;

      // reset in GAP, stray second pulse, then recovery
      chosen_interrupt = 8'h02;
      step();
      inta_n = 1'b0; step();
      inta_n = 1'b1; step();
      check_eq("gap_busy", 32'(busy), 32'd1);
      apply_reset();
      int_req = 1'b0;
      inta_n = 1'b0; step(); step();
      inta_n = 1'b1; step();
      check_eq("stray_busy", 32'(busy), 32'd0);
      check_eq("stray_oe", 32'(data_oe), 32'd0);
      int_req = 1'b1; chosen_interrupt = 8'h01; vector_base = 5'b10101;
      step();
      inta_pulses();
      check_eq("resume_vec", 32'(vec_seen), 32'hA8);

      // randomized traffic
      for (int n = 0; n < 4000; n++) begin
         int r;
         int_req = ($urandom_range(3) != 0);
         r = $urandom_range(3);
         if (r == 0)      chosen_interrupt = 8'h00;
         else if (r == 1) chosen_interrupt = 8'($urandom);
         else             chosen_interrupt = 8'(1 << $urandom_range(7));
         if ($urandom_range(2) == 0) inta_n = ~inta_n;
         eoi_valid    = ($urandom_range(7) == 0);
         eoi_specific = 1'($urandom);
         eoi_level    = 3'($urandom);
         if ($urandom_range(63) == 0) aeoi = ~aeoi;
         if ($urandom_range(31) == 0) vector_base = 5'($urandom);
         if ($urandom_range(499) == 0) apply_reset();
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
